// File: rtl/pipeline_exec_controller_pkg.sv
// Shared definitions for the pipeline execution controller: host command codes,
// controller states, the HALT opcode and state-decode helpers.
package pipeline_exec_controller_pkg;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_PAUSE = 2'b10,
        CMD_CLEAR = 2'b11
    } exec_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED
    } exec_state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    function automatic logic state_is_busy(exec_state_t s);
        return s inside {ST_RUN, ST_STEP, ST_DRAIN};
    endfunction

    // Commands are refused only while a step or a drain is in flight.
    function automatic logic state_is_ready(exec_state_t s);
        return s inside {ST_IDLE, ST_RUN, ST_HALTED};
    endfunction

endpackage

// File: rtl/pipeline_exec_controller_if.sv
// Host command / pipeline-enable bundle of the execution controller.
// master = debug host side, slave = controller side.
interface pipeline_exec_controller_if #(
    parameter int NB = 32
);
    logic          i_cmd_valid;
    logic [1:0]    i_cmd;
    logic          o_cmd_ready;
    logic          i_halt_detected;
    logic          o_pc_enable;
    logic          o_pipe_enable;
    logic          o_halted;
    logic          o_busy;
    logic          o_cmd_err;
    logic [NB-1:0] o_cycle_count;
    logic          o_timeout;

    modport master (
        output i_cmd_valid, i_cmd, i_halt_detected,
        input  o_cmd_ready, o_pc_enable, o_pipe_enable, o_halted,
               o_busy, o_cmd_err, o_cycle_count, o_timeout
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_halt_detected,
        output o_cmd_ready, o_pc_enable, o_pipe_enable, o_halted,
               o_busy, o_cmd_err, o_cycle_count, o_timeout
    );
endinterface

// File: rtl/pipeline_exec_controller_sat_counter.sv
// NB-bit up counter with synchronous clear and enable; holds at all-ones instead of wrapping.
module pipeline_exec_controller_sat_counter #(
    parameter int NB = 32
) (
    input  logic          i_clk,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [NB-1:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            o_count <= '0;
        end else if (i_enable && (o_count != '1)) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_exec_controller.sv
// Debug-host sequencer for the 5-stage pipeline: run / step / pause / halt-and-drain.
// Build option EXEC_CTRL_WATCHDOG_EN adds a cycle-count watchdog that forces a drain.
module pipeline_exec_controller
    import pipeline_exec_controller_pkg::*;
#(
    parameter int          NB             = 32,
    parameter int          DRAIN_CYCLES   = 4,
    parameter int          NB_DRAIN       = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFF0
) (
    input logic                     i_clk,
    input logic                     i_reset,
    pipeline_exec_controller_if.slave bus
);

    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    exec_state_t         state;
    exec_state_t         state_nxt;
    exec_cmd_t           cmd;
    logic                accept;
    logic                wd_hit;
    logic                halt_trig;
    logic                pc_en;
    logic                pipe_en;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic [NB_DRAIN-1:0] drain_nxt;
    logic                err_nxt;
    logic                cnt_clear;
    logic [NB-1:0]       cycle_count;
    logic                cmd_ready_q;
    logic                halted_q;
    logic                busy_q;
    logic                cmd_err_q;

    assign cmd    = exec_cmd_t'(bus.i_cmd);
    assign accept = bus.i_cmd_valid & cmd_ready_q;

`ifdef EXEC_CTRL_WATCHDOG_EN
    localparam logic [NB-1:0] TIMEOUT_NB = NB'(TIMEOUT_CYCLES);

    logic timeout_q;

    assign wd_hit = (state == ST_RUN) && (cycle_count >= TIMEOUT_NB);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            timeout_q <= 1'b0;
        end else if (accept && (cmd == CMD_CLEAR) && (state inside {ST_IDLE, ST_HALTED})) begin
            timeout_q <= 1'b0;
        end else if (wd_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    assign wd_hit        = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    // Halt only matters while instructions are being fetched; the fetch that saw it is squashed.
    assign halt_trig = (state inside {ST_RUN, ST_STEP}) && (bus.i_halt_detected || wd_hit);
    assign pc_en     = (state inside {ST_RUN, ST_STEP}) && !halt_trig;
    assign pipe_en   = state inside {ST_RUN, ST_STEP, ST_DRAIN};

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        err_nxt   = 1'b0;
        cnt_clear = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_RUN:   state_nxt = ST_RUN;
                        CMD_STEP:  state_nxt = ST_STEP;
                        CMD_CLEAR: cnt_clear = 1'b1;
                        default:   err_nxt   = 1'b1;
                    endcase
                end
            end

            ST_RUN: begin
                if (accept) begin
                    if (cmd == CMD_PAUSE) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                // Halt overrides a same-cycle PAUSE, which is then silently dropped.
                if (halt_trig) begin
                    if (DRAIN_CYCLES > 1) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end else begin
                        state_nxt = ST_HALTED;
                    end
                end
            end

            ST_STEP: begin
                state_nxt = ST_IDLE;
                if (halt_trig) begin
                    if (DRAIN_CYCLES > 1) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end else begin
                        state_nxt = ST_HALTED;
                    end
                end
            end

            ST_DRAIN: begin
                drain_nxt = drain_cnt - 1'b1;
                if (drain_cnt <= NB_DRAIN'(1)) begin
                    state_nxt = ST_HALTED;
                end
            end

            ST_HALTED: begin
                if (accept) begin
                    if (cmd == CMD_CLEAR) begin
                        state_nxt = ST_IDLE;
                        cnt_clear = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            cmd_ready_q <= 1'b1;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_nxt;
            cmd_ready_q <= state_is_ready(state_nxt);
            halted_q    <= (state_nxt == ST_HALTED);
            busy_q      <= state_is_busy(state_nxt);
            cmd_err_q   <= err_nxt;
        end
    end

    pipeline_exec_controller_sat_counter #(
        .NB (NB)
    ) u_cycle_counter (
        .i_clk    (i_clk),
        .i_clear  (i_reset | cnt_clear),
        .i_enable (pipe_en),
        .o_count  (cycle_count)
    );

    assign bus.o_cmd_ready   = cmd_ready_q;
    assign bus.o_pc_enable   = pc_en;
    assign bus.o_pipe_enable = pipe_en;
    assign bus.o_halted      = halted_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_cmd_err     = cmd_err_q;
    assign bus.o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller: per-cycle vector table plus
// hand-written saturation / watchdog sequences.
module tb_pipeline_exec_controller;

    localparam logic [1:0] C_RUN   = 2'b00;
    localparam logic [1:0] C_STEP  = 2'b01;
    localparam logic [1:0] C_PAUSE = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    typedef struct packed {
        logic       pc;
        logic       pipe;
        logic       rdy;
        logic       hlt;
        logic       busy;
        logic       err;
        logic [7:0] cnt;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] cmd;
        logic       halt;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];

    pipeline_exec_controller_if #(.NB(8)) bus ();

    pipeline_exec_controller #(
        .NB             (8),
        .DRAIN_CYCLES   (4),
        .NB_DRAIN       (3),
        .TIMEOUT_CYCLES (32'd20)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o.pc   = bus.o_pc_enable;
        o.pipe = bus.o_pipe_enable;
        o.rdy  = bus.o_cmd_ready;
        o.hlt  = bus.o_halted;
        o.busy = bus.o_busy;
        o.err  = bus.o_cmd_err;
        o.cnt  = bus.o_cycle_count;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One clock: drive just after the edge, sample at the falling edge.
    task automatic cyc(input logic r, input logic v, input logic [1:0] c, input logic h);
        @(posedge clk);
        #1;
        rst                 = r;
        bus.i_cmd_valid     = v;
        bus.i_cmd           = c;
        bus.i_halt_detected = h;
        @(negedge clk);
    endtask

    task automatic add(input logic r, input logic v, input logic [1:0] c, input logic h,
                       input logic pc, input logic pipe, input logic rdy, input logic hlt,
                       input logic busy, input logic err, input int cnt);
        vec_t e;
        e.rst      = r;
        e.v        = v;
        e.cmd      = c;
        e.halt     = h;
        e.exp.pc   = pc;
        e.exp.pipe = pipe;
        e.exp.rdy  = rdy;
        e.exp.hlt  = hlt;
        e.exp.busy = busy;
        e.exp.err  = err;
        e.exp.cnt  = 8'(cnt);
        tbl.push_back(e);
    endtask

    initial begin
        int n;
        outs_t rs;

        // Run to halt with HALT seen in the 11th RUN cycle, then illegal RUN and CLEAR in HALTED.
        add(0, 1, C_RUN, 0,   0, 0, 1, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) add(0, 0, C_RUN, 0,   1, 1, 1, 0, 1, 0, j);
        add(0, 0, C_RUN, 1,   0, 1, 1, 0, 1, 0, 10);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 11);
        add(0, 0, C_RUN, 1,   0, 1, 0, 0, 1, 0, 12);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 13);
        add(0, 1, C_RUN, 0,   0, 0, 1, 1, 0, 0, 14);
        add(0, 1, C_CLEAR, 0, 0, 0, 1, 1, 0, 1, 14);
        add(0, 1, C_STEP, 0,  0, 0, 1, 0, 0, 0, 0);
        // Three single steps; STEP offered while not ready must not be taken.
        for (int k = 0; k < 3; k++) begin
            add(0, 1, C_STEP, 0, 1, 1, 0, 0, 1, 0, k);
            add(0, 1, (k < 2) ? C_STEP : C_PAUSE, 0, 0, 0, 1, 0, 0, 0, k + 1);
        end
        add(0, 0, C_RUN, 0,   0, 0, 1, 0, 0, 1, 3);
        add(0, 1, C_RUN, 0,   0, 0, 1, 0, 0, 0, 3);
        // Run, pause, resume, illegal CLEAR in RUN, PAUSE colliding with HALT, reset mid-drain.
        add(0, 0, C_RUN, 0,   1, 1, 1, 0, 1, 0, 3);
        add(0, 0, C_RUN, 0,   1, 1, 1, 0, 1, 0, 4);
        add(0, 1, C_PAUSE, 0, 1, 1, 1, 0, 1, 0, 5);
        add(0, 1, C_RUN, 0,   0, 0, 1, 0, 0, 0, 6);
        add(0, 0, C_RUN, 0,   1, 1, 1, 0, 1, 0, 6);
        add(0, 1, C_CLEAR, 0, 1, 1, 1, 0, 1, 0, 7);
        add(0, 1, C_PAUSE, 1, 0, 1, 1, 0, 1, 1, 8);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 9);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 10);
        add(1, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 11);
        // After reset: STEP that decodes HALT drains straight from the step.
        add(0, 1, C_STEP, 0,  0, 0, 1, 0, 0, 0, 0);
        add(0, 0, C_RUN, 1,   0, 1, 0, 0, 1, 0, 0);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 1);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 2);
        add(0, 0, C_RUN, 0,   0, 1, 0, 0, 1, 0, 3);
        add(0, 1, C_CLEAR, 0, 0, 0, 1, 1, 0, 0, 4);
        add(0, 0, C_RUN, 0,   0, 0, 1, 0, 0, 0, 0);

        bus.i_cmd_valid     = 1'b0;
        bus.i_cmd           = C_RUN;
        bus.i_halt_detected = 1'b0;

        cyc(1, 0, C_RUN, 0);
        cyc(1, 0, C_RUN, 0);
        rs = sample();
        check("reset_state", 32'(rs), 32'(outs_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        check("reset_timeout", 32'(bus.o_timeout), 32'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].v, tbl[i].cmd, tbl[i].halt);
            total++;
            if (sample() !== tbl[i].exp) begin
                bad++;
                $display("FAIL vec%0d act=%b exp=%b", i, sample(), tbl[i].exp);
            end
        end

`ifdef EXEC_CTRL_WATCHDOG_EN
        cyc(0, 1, C_RUN, 0);
        cyc(0, 0, C_RUN, 0);
        n = 0;
        while (!(bus.o_pipe_enable && !bus.o_pc_enable) && n < 40) begin
            cyc(0, 0, C_RUN, 0);
            n++;
        end
        check("wd_fire_count", 32'(bus.o_cycle_count), 32'd20);
        check("wd_fire_pc", {30'd0, bus.o_pc_enable, bus.o_pipe_enable}, 32'd1);
        n = 0;
        while (!bus.o_halted && n < 10) begin
            cyc(0, 0, C_RUN, 0);
            n++;
        end
        check("wd_drain_len", 32'(n), 32'd4);
        check("wd_halt_count", 32'(bus.o_cycle_count), 32'd24);
        check("wd_timeout_set", 32'(bus.o_timeout), 32'd1);
        cyc(0, 1, C_CLEAR, 0);
        cyc(0, 0, C_RUN, 0);
        check("wd_timeout_clr", {29'd0, bus.o_timeout, bus.o_halted, 1'b0}, 32'd0);
        check("wd_count_clr", 32'(bus.o_cycle_count), 32'd0);
`else
        cyc(0, 1, C_RUN, 0);
        for (int j = 0; j < 260; j++) cyc(0, 0, C_RUN, 0);
        check("sat_count", 32'(bus.o_cycle_count), 32'hFF);
        check("sat_pipe", {30'd0, bus.o_pc_enable, bus.o_pipe_enable}, 32'd3);
        cyc(0, 0, C_RUN, 0);
        check("sat_hold", 32'(bus.o_cycle_count), 32'hFF);
        cyc(0, 1, C_PAUSE, 0);
        cyc(0, 0, C_RUN, 0);
        check("sat_paused", {30'd0, bus.o_pc_enable, bus.o_busy}, 32'd0);
        check("no_timeout", 32'(bus.o_timeout), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
